// File: rtl/avr_sp_sreg_pkg.sv
// Shared constants and types for the AVR stack pointer / status register block.
package avr_sp_sreg_pkg;

    // I/O addresses of the registers owned by this block
    localparam logic [5:0] ADR_SPL  = 6'h3D;
    localparam logic [5:0] ADR_SPH  = 6'h3E;
    localparam logic [5:0] ADR_SREG = 6'h3F;

    // SREG bit positions
    localparam int SREG_I = 7;
    localparam int SREG_T = 6;
    localparam int SREG_H = 5;
    localparam int SREG_S = 4;
    localparam int SREG_V = 3;
    localparam int SREG_N = 2;
    localparam int SREG_Z = 1;
    localparam int SREG_C = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP_RD,
        ST_POP_CAP,
        ST_CALL_B0,
        ST_CALL_B1,
        ST_CALL_B2,
        ST_RET_B2,
        ST_RET_B1,
        ST_RET_B0,
        ST_RET_CAP
    } stk_state_e;

endpackage

// File: rtl/avr_sreg_upd.sv
// Combinational per-bit SREG next-state selection (reset is applied by the owner flop).
module avr_sreg_upd
    import avr_sp_sreg_pkg::*;
(
    input  logic [7:0] sreg_cur,
    input  logic       io_we,
    input  logic [7:0] io_data,
    input  logic [7:0] fl_in,
    input  logic [7:0] fl_we,
    input  logic       i_clr,
    input  logic       i_set,
    output logic [7:0] sreg_nxt
);

    // Per bit: I/O write, then I-flag strobes (clear beats set), then ALU enable
    always_comb begin
        sreg_nxt = sreg_cur;
        for (int b = 0; b < 8; b++) begin
            if (io_we) begin
                sreg_nxt[b] = io_data[b];
            end else if ((b == SREG_I) && i_clr) begin
                sreg_nxt[b] = 1'b0;
            end else if ((b == SREG_I) && i_set) begin
                sreg_nxt[b] = 1'b1;
            end else if (fl_we[b]) begin
                sreg_nxt[b] = fl_in[b];
            end
        end
    end

endmodule

// File: rtl/avr_sp_sreg.sv
// AVR stack pointer, status register and stack transfer sequencer.
// Optional build macro SP_LIMIT_CHK_EN adds a sticky stack-limit error flag.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a request; I/O writes to SP accepted here only
// ST_PUSH    | single-byte write strobe on the bus
// ST_POP_RD  | read strobe at pre-incremented SP
// ST_POP_CAP | read data on stk_rdata, captured into pop_data
// ST_CALL_B0 | write of return address bits [7:0]
// ST_CALL_B1 | write of return address bits [15:8]
// ST_CALL_B2 | write of return address bits [21:16] (22-bit PC only)
// ST_RET_B2  | read of return address bits [21:16] (22-bit PC only)
// ST_RET_B1  | read of bits [15:8]; captures [21:16] when 22-bit PC
// ST_RET_B0  | read of bits [7:0]; captures [15:8]
// ST_RET_CAP | captures [7:0] and presents pc_out
module avr_sp_sreg
    import avr_sp_sreg_pkg::*;
#(
    parameter bit          pc22b    = 1'b0,
    parameter logic [15:0] SP_RST   = 16'h08FF,
    parameter logic [15:0] SP_LIMIT = 16'h0100
) (
    input  logic        cp2,
    input  logic        ireset,
    input  logic [5:0]  adr,
    input  logic        iowe,
    input  logic [7:0]  dbusout,
    output logic [7:0]  spl_out,
    output logic [7:0]  sph_out,
    output logic [7:0]  sreg_out,
    input  logic [7:0]  sreg_fl_in,
    input  logic [7:0]  sreg_fl_we,
    input  logic        sreg_i_clr,
    input  logic        sreg_i_set,
    input  logic        push_req,
    input  logic [7:0]  push_data,
    input  logic        pop_req,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [21:0] pc_in,
    output logic [15:0] stk_adr,
    output logic [7:0]  stk_wdata,
    output logic        stk_we,
    output logic        stk_re,
    input  logic [7:0]  stk_rdata,
    output logic [7:0]  pop_data,
    output logic        pop_vld,
    output logic [21:0] pc_out,
    output logic        pc_vld,
    output logic        busy,
    output logic        stk_err
);

    stk_state_e  state_q, state_d;
    logic [15:0] sp_q, sp_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [13:0] pc_hi_q, pc_hi_d;
    logic [5:0]  rd_b2_q, rd_b2_d;
    logic [7:0]  rd_b1_q, rd_b1_d;
    logic [15:0] stk_adr_q, stk_adr_d;
    logic [7:0]  stk_wdata_q, stk_wdata_d;
    logic        stk_we_q, stk_we_d;
    logic        stk_re_q, stk_re_d;
    logic [7:0]  pop_data_q, pop_data_d;
    logic        pop_vld_q, pop_vld_d;
    logic [21:0] pc_out_q, pc_out_d;
    logic        pc_vld_q, pc_vld_d;

    logic        sp_io_wr;
    logic        sreg_io_we;
    logic [15:0] sp_inc;
    logic [15:0] sp_dec;

    assign sp_io_wr   = iowe && ((adr == ADR_SPL) || (adr == ADR_SPH));
    assign sreg_io_we = iowe && (adr == ADR_SREG);
    assign sp_inc     = sp_q + 16'd1;
    assign sp_dec     = sp_q - 16'd1;

    avr_sreg_upd u_sreg_upd (
        .sreg_cur (sreg_q),
        .io_we    (sreg_io_we),
        .io_data  (dbusout),
        .fl_in    (sreg_fl_in),
        .fl_we    (sreg_fl_we),
        .i_clr    (sreg_i_clr),
        .i_set    (sreg_i_set),
        .sreg_nxt (sreg_d)
    );

    // Sequencer next state; bus strobes are set up on the edge that enters each state
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        pc_hi_d     = pc_hi_q;
        rd_b2_d     = rd_b2_q;
        rd_b1_d     = rd_b1_q;
        stk_adr_d   = stk_adr_q;
        stk_wdata_d = stk_wdata_q;
        stk_we_d    = 1'b0;
        stk_re_d    = 1'b0;
        pop_data_d  = pop_data_q;
        pop_vld_d   = 1'b0;
        pc_out_d    = pc_out_q;
        pc_vld_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // An SP write in the same cycle as a request wins and drops the request
                if (sp_io_wr) begin
                    if (adr == ADR_SPL) sp_d[7:0]  = dbusout;
                    else                sp_d[15:8] = dbusout;
                end else if (call_req) begin
                    state_d     = ST_CALL_B0;
                    pc_hi_d     = pc_in[21:8];
                    stk_we_d    = 1'b1;
                    stk_adr_d   = sp_q;
                    stk_wdata_d = pc_in[7:0];
                    sp_d        = sp_dec;
                end else if (ret_req) begin
                    state_d   = pc22b ? ST_RET_B2 : ST_RET_B1;
                    stk_re_d  = 1'b1;
                    stk_adr_d = sp_inc;
                    sp_d      = sp_inc;
                end else if (push_req) begin
                    state_d     = ST_PUSH;
                    stk_we_d    = 1'b1;
                    stk_adr_d   = sp_q;
                    stk_wdata_d = push_data;
                    sp_d        = sp_dec;
                end else if (pop_req) begin
                    state_d   = ST_POP_RD;
                    stk_re_d  = 1'b1;
                    stk_adr_d = sp_inc;
                    sp_d      = sp_inc;
                end
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
            end
            ST_POP_RD: begin
                state_d = ST_POP_CAP;
            end
            ST_POP_CAP: begin
                pop_data_d = stk_rdata;
                pop_vld_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_CALL_B0: begin
                state_d     = ST_CALL_B1;
                stk_we_d    = 1'b1;
                stk_adr_d   = sp_q;
                stk_wdata_d = pc_hi_q[7:0];
                sp_d        = sp_dec;
            end
            ST_CALL_B1: begin
                if (pc22b) begin
                    state_d     = ST_CALL_B2;
                    stk_we_d    = 1'b1;
                    stk_adr_d   = sp_q;
                    stk_wdata_d = {2'b00, pc_hi_q[13:8]};
                    sp_d        = sp_dec;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALL_B2: begin
                state_d = ST_IDLE;
            end
            ST_RET_B2: begin
                state_d   = ST_RET_B1;
                stk_re_d  = 1'b1;
                stk_adr_d = sp_inc;
                sp_d      = sp_inc;
            end
            ST_RET_B1: begin
                if (pc22b) rd_b2_d = stk_rdata[5:0];
                state_d   = ST_RET_B0;
                stk_re_d  = 1'b1;
                stk_adr_d = sp_inc;
                sp_d      = sp_inc;
            end
            ST_RET_B0: begin
                rd_b1_d = stk_rdata;
                state_d = ST_RET_CAP;
            end
            ST_RET_CAP: begin
                pc_out_d = {(pc22b ? rd_b2_q : 6'd0), rd_b1_q, stk_rdata};
                pc_vld_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update; reset abandons any transfer in flight
    always_ff @(posedge cp2) begin
        if (ireset) begin
            state_q     <= ST_IDLE;
            sp_q        <= SP_RST;
            sreg_q      <= 8'h00;
            pc_hi_q     <= 14'd0;
            rd_b2_q     <= 6'd0;
            rd_b1_q     <= 8'h00;
            stk_adr_q   <= 16'h0000;
            stk_wdata_q <= 8'h00;
            stk_we_q    <= 1'b0;
            stk_re_q    <= 1'b0;
            pop_data_q  <= 8'h00;
            pop_vld_q   <= 1'b0;
            pc_out_q    <= 22'd0;
            pc_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            sreg_q      <= sreg_d;
            pc_hi_q     <= pc_hi_d;
            rd_b2_q     <= rd_b2_d;
            rd_b1_q     <= rd_b1_d;
            stk_adr_q   <= stk_adr_d;
            stk_wdata_q <= stk_wdata_d;
            stk_we_q    <= stk_we_d;
            stk_re_q    <= stk_re_d;
            pop_data_q  <= pop_data_d;
            pop_vld_q   <= pop_vld_d;
            pc_out_q    <= pc_out_d;
            pc_vld_q    <= pc_vld_d;
        end
    end

`ifdef SP_LIMIT_CHK_EN
    logic stk_err_q, stk_err_d;

    // Sticky flag: any write strobe below the legal stack floor
    always_comb begin
        stk_err_d = stk_err_q | (stk_we_q && (stk_adr_q < SP_LIMIT));
    end

    // Error flag register
    always_ff @(posedge cp2) begin
        if (ireset) stk_err_q <= 1'b0;
        else        stk_err_q <= stk_err_d;
    end

    assign stk_err = stk_err_q;
`else
    assign stk_err = 1'b0;
`endif

    assign spl_out   = sp_q[7:0];
    assign sph_out   = sp_q[15:8];
    assign sreg_out  = sreg_q;
    assign stk_adr   = stk_adr_q;
    assign stk_wdata = stk_wdata_q;
    assign stk_we    = stk_we_q;
    assign stk_re    = stk_re_q;
    assign pop_data  = pop_data_q;
    assign pop_vld   = pop_vld_q;
    assign pc_out    = pc_out_q;
    assign pc_vld    = pc_vld_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avr_sp_sreg.sv
// Scoreboard bench for avr_sp_sreg: one instance with 16-bit PC, one with 22-bit PC.
module tb_avr_sp_sreg;

`ifdef SP_LIMIT_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] SENT = 32'h8000_0000;

    logic        cp2 = 1'b0;
    logic        ireset;
    logic [5:0]  adr;
    logic        iowe;
    logic [7:0]  dbusout;
    logic [7:0]  sreg_fl_in, sreg_fl_we;
    logic        sreg_i_clr, sreg_i_set;
    logic        push_req, pop_req, call_req, ret_req;
    logic        call_req1, ret_req1;
    logic [7:0]  push_data;
    logic [21:0] pc_in;

    logic [7:0]  spl0, sph0, sreg0, stk_wdata0, stk_rdata0, pop_data0;
    logic [15:0] stk_adr0;
    logic        stk_we0, stk_re0, pop_vld0, pc_vld0, busy0, stk_err0;
    logic [21:0] pc_out0;

    logic [7:0]  spl1, sph1, sreg1, stk_wdata1, stk_rdata1, pop_data1;
    logic [15:0] stk_adr1;
    logic        stk_we1, stk_re1, pop_vld1, pc_vld1, busy1, stk_err1;
    logic [21:0] pc_out1;

    logic [7:0]  mem0 [65536];
    logic [7:0]  mem1 [65536];

    logic [23:0] wr0_q[$], wr1_q[$];
    logic [15:0] rd0_q[$], rd1_q[$];
    logic [7:0]  pop0_q[$];
    logic [21:0] pc0_q[$], pc1_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 cp2 = ~cp2;

    avr_sp_sreg #(.pc22b(1'b0)) u_dut0 (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iowe(iowe), .dbusout(dbusout),
        .spl_out(spl0), .sph_out(sph0), .sreg_out(sreg0),
        .sreg_fl_in(sreg_fl_in), .sreg_fl_we(sreg_fl_we),
        .sreg_i_clr(sreg_i_clr), .sreg_i_set(sreg_i_set),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .call_req(call_req), .ret_req(ret_req), .pc_in(pc_in),
        .stk_adr(stk_adr0), .stk_wdata(stk_wdata0), .stk_we(stk_we0), .stk_re(stk_re0),
        .stk_rdata(stk_rdata0), .pop_data(pop_data0), .pop_vld(pop_vld0),
        .pc_out(pc_out0), .pc_vld(pc_vld0), .busy(busy0), .stk_err(stk_err0)
    );

    avr_sp_sreg #(.pc22b(1'b1)) u_dut1 (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iowe(1'b0), .dbusout(dbusout),
        .spl_out(spl1), .sph_out(sph1), .sreg_out(sreg1),
        .sreg_fl_in(8'h00), .sreg_fl_we(8'h00),
        .sreg_i_clr(1'b0), .sreg_i_set(1'b0),
        .push_req(1'b0), .push_data(push_data), .pop_req(1'b0),
        .call_req(call_req1), .ret_req(ret_req1), .pc_in(pc_in),
        .stk_adr(stk_adr1), .stk_wdata(stk_wdata1), .stk_we(stk_we1), .stk_re(stk_re1),
        .stk_rdata(stk_rdata1), .pop_data(pop_data1), .pop_vld(pop_vld1),
        .pc_out(pc_out1), .pc_vld(pc_vld1), .busy(busy1), .stk_err(stk_err1)
    );

    // Stack RAM models, one-cycle read latency
    always @(posedge cp2) begin
        if (stk_we0) mem0[stk_adr0] <= stk_wdata0;
        if (stk_re0) stk_rdata0 <= mem0[stk_adr0];
        if (stk_we1) mem1[stk_adr1] <= stk_wdata1;
        if (stk_re1) stk_rdata1 <= mem1[stk_adr1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge cp2) begin
        logic [31:0] e;
        if (stk_we0) begin
            e = SENT; if (wr0_q.size() > 0) e = 32'(wr0_q.pop_front());
            check_eq("wr0", {8'h00, stk_adr0, stk_wdata0}, e);
        end
        if (stk_re0) begin
            e = SENT; if (rd0_q.size() > 0) e = 32'(rd0_q.pop_front());
            check_eq("rd0", {16'h0, stk_adr0}, e);
        end
        if (pop_vld0) begin
            e = SENT; if (pop0_q.size() > 0) e = 32'(pop0_q.pop_front());
            check_eq("pop0", {24'h0, pop_data0}, e);
        end
        if (pc_vld0) begin
            e = SENT; if (pc0_q.size() > 0) e = 32'(pc0_q.pop_front());
            check_eq("pc0", {10'h0, pc_out0}, e);
        end
        if (stk_we1) begin
            e = SENT; if (wr1_q.size() > 0) e = 32'(wr1_q.pop_front());
            check_eq("wr1", {8'h00, stk_adr1, stk_wdata1}, e);
        end
        if (stk_re1) begin
            e = SENT; if (rd1_q.size() > 0) e = 32'(rd1_q.pop_front());
            check_eq("rd1", {16'h0, stk_adr1}, e);
        end
        if (pc_vld1) begin
            e = SENT; if (pc1_q.size() > 0) e = 32'(pc1_q.pop_front());
            check_eq("pc1", {10'h0, pc_out1}, e);
        end
    end

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? busy1 : busy0) && n < 20) begin
            tick();
            n++;
        end
        check_eq(sel ? "idle1" : "idle0", {31'd0, (sel ? busy1 : busy0)}, 32'd0);
    endtask

    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        iowe = 1'b1; adr = a; dbusout = d;
        tick();
        iowe = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] d);
        push_req = 1'b1; push_data = d;
        tick();
        push_req = 1'b0;
        wait_idle(1'b0);
    endtask

    task automatic do_pop();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        wait_idle(1'b0);
    endtask

    task automatic sreg_step(input string tag, input logic io, input logic [7:0] d,
                             input logic clr, input logic set, input logic [7:0] we,
                             input logic [7:0] fl, input logic [7:0] exp);
        iowe = io; adr = 6'h3F; dbusout = d;
        sreg_i_clr = clr; sreg_i_set = set; sreg_fl_we = we; sreg_fl_in = fl;
        tick();
        iowe = 1'b0; sreg_i_clr = 1'b0; sreg_i_set = 1'b0; sreg_fl_we = 8'h00;
        check_eq(tag, {24'h0, sreg0}, {24'h0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ireset = 1'b1; adr = 6'h0; iowe = 1'b0; dbusout = 8'h00;
        sreg_fl_in = 8'h00; sreg_fl_we = 8'h00; sreg_i_clr = 1'b0; sreg_i_set = 1'b0;
        push_req = 1'b0; pop_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
        call_req1 = 1'b0; ret_req1 = 1'b0; push_data = 8'h00; pc_in = 22'd0;
        repeat (3) tick();
        ireset = 1'b0;

        check_eq("rst_spl", {24'h0, spl0}, 32'hFF);
        check_eq("rst_sph", {24'h0, sph0}, 32'h08);
        check_eq("rst_sreg", {24'h0, sreg0}, 32'h00);
        check_eq("rst_busy", {31'h0, busy0}, 32'h0);
        check_eq("rst_err", {31'h0, stk_err0}, 32'h0);
        check_eq("rst_sp1", {16'h0, sph1, spl1}, 32'h08FF);

        // push / pop round trip
        wr0_q.push_back({16'h08FF, 8'hA5});
        do_push(8'hA5);
        check_eq("push_sp", {16'h0, sph0, spl0}, 32'h08FE);
        rd0_q.push_back(16'h08FF); pop0_q.push_back(8'hA5);
        do_pop();
        check_eq("pop_sp", {16'h0, sph0, spl0}, 32'h08FF);

        // 16-bit return address; upper pc_in bits must be ignored
        pc_in = 22'h3F1234;
        wr0_q.push_back({16'h08FF, 8'h34}); wr0_q.push_back({16'h08FE, 8'h12});
        call_req = 1'b1; tick(); call_req = 1'b0; wait_idle(1'b0);
        check_eq("call_sp", {16'h0, sph0, spl0}, 32'h08FD);
        rd0_q.push_back(16'h08FE); rd0_q.push_back(16'h08FF); pc0_q.push_back(22'h001234);
        ret_req = 1'b1; tick(); ret_req = 1'b0; wait_idle(1'b0);
        check_eq("ret_sp", {16'h0, sph0, spl0}, 32'h08FF);

        // 22-bit return address on the second instance
        pc_in = 22'h2ABCDE;
        wr1_q.push_back({16'h08FF, 8'hDE}); wr1_q.push_back({16'h08FE, 8'hBC});
        wr1_q.push_back({16'h08FD, 8'h2A});
        call_req1 = 1'b1; tick(); call_req1 = 1'b0; wait_idle(1'b1);
        check_eq("call1_sp", {16'h0, sph1, spl1}, 32'h08FC);
        rd1_q.push_back(16'h08FD); rd1_q.push_back(16'h08FE); rd1_q.push_back(16'h08FF);
        pc1_q.push_back(22'h2ABCDE);
        ret_req1 = 1'b1; tick(); ret_req1 = 1'b0; wait_idle(1'b1);
        check_eq("ret1_sp", {16'h0, sph1, spl1}, 32'h08FF);

        // SREG priority
        sreg_step("sreg_io_win", 1'b1, 8'h80, 1'b1, 1'b0, 8'h02, 8'hFF, 8'h80);
        check_eq("sreg_sp_kept", {16'h0, sph0, spl0}, 32'h08FF);
        sreg_step("sreg_iclr",   1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        sreg_step("sreg_alu",    1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 8'h01, 8'h01);
        sreg_step("sreg_iset",   1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h81);
        sreg_step("sreg_clr_set",1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 8'h01);
        sreg_step("sreg_set_alu",1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 8'h00, 8'h81);
        sreg_step("sreg_clr_alu",1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h80, 8'h01);

        // SP loads, stack limit and wrap-around
        io_wr(6'h3D, 8'h00);
        io_wr(6'h3E, 8'h01);
        check_eq("io_sp", {16'h0, sph0, spl0}, 32'h0100);
        wr0_q.push_back({16'h0100, 8'h11});
        do_push(8'h11);
        check_eq("lim_ok_err", {31'h0, stk_err0}, 32'(ERR_EN & 1'b0));
        wr0_q.push_back({16'h00FF, 8'h22});
        do_push(8'h22);
        check_eq("lim_err", {31'h0, stk_err0}, {31'h0, ERR_EN});
        io_wr(6'h3E, 8'h00);
        io_wr(6'h3D, 8'h00);
        wr0_q.push_back({16'h0000, 8'h5A});
        do_push(8'h5A);
        check_eq("wrap_dn_sp", {16'h0, sph0, spl0}, 32'hFFFF);
        rd0_q.push_back(16'h0000); pop0_q.push_back(8'h5A);
        do_pop();
        check_eq("wrap_up_sp", {16'h0, sph0, spl0}, 32'h0000);
        check_eq("err_sticky", {31'h0, stk_err0}, {31'h0, ERR_EN});

        // SP write while busy is dropped
        io_wr(6'h3E, 8'h08);
        wr0_q.push_back({16'h0800, 8'h33});
        push_req = 1'b1; push_data = 8'h33; tick(); push_req = 1'b0;
        iowe = 1'b1; adr = 6'h3D; dbusout = 8'h11; tick(); iowe = 1'b0;
        wait_idle(1'b0);
        check_eq("busy_drop_sp", {16'h0, sph0, spl0}, 32'h07FF);

        // SP write in the acceptance cycle discards the request
        iowe = 1'b1; adr = 6'h3E; dbusout = 8'h05; push_req = 1'b1; push_data = 8'h44;
        tick();
        iowe = 1'b0; push_req = 1'b0;
        check_eq("coinc_busy", {31'h0, busy0}, 32'h0);
        check_eq("coinc_sp", {16'h0, sph0, spl0}, 32'h05FF);

        // Request priority
        pc_in = 22'h0055AA;
        wr0_q.push_back({16'h05FF, 8'hAA}); wr0_q.push_back({16'h05FE, 8'h55});
        call_req = 1'b1; ret_req = 1'b1; push_req = 1'b1; pop_req = 1'b1;
        tick();
        call_req = 1'b0; ret_req = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        wait_idle(1'b0);
        check_eq("prio_call_sp", {16'h0, sph0, spl0}, 32'h05FD);
        rd0_q.push_back(16'h05FE); rd0_q.push_back(16'h05FF); pc0_q.push_back(22'h0055AA);
        ret_req = 1'b1; push_req = 1'b1; pop_req = 1'b1;
        tick();
        ret_req = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        wait_idle(1'b0);
        check_eq("prio_ret_sp", {16'h0, sph0, spl0}, 32'h05FF);

        // Reset in the middle of a call: only the first byte is written
        pc_in = 22'h000777;
        wr0_q.push_back({16'h05FF, 8'h77});
        call_req = 1'b1; tick(); call_req = 1'b0;
        ireset = 1'b1; tick(); ireset = 1'b0;
        check_eq("mid_rst_busy", {31'h0, busy0}, 32'h0);
        check_eq("mid_rst_sp", {16'h0, sph0, spl0}, 32'h08FF);
        check_eq("mid_rst_sreg", {24'h0, sreg0}, 32'h00);
        check_eq("mid_rst_err", {31'h0, stk_err0}, 32'h0);
        repeat (4) tick();

        check_eq("wr0_left", wr0_q.size(), 32'd0);
        check_eq("rd0_left", rd0_q.size(), 32'd0);
        check_eq("pop0_left", pop0_q.size(), 32'd0);
        check_eq("pc0_left", pc0_q.size(), 32'd0);
        check_eq("wr1_left", wr1_q.size(), 32'd0);
        check_eq("rd1_left", rd1_q.size(), 32'd0);
        check_eq("pc1_left", pc1_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avr_sp_sreg.md
Name: avr_sp_sreg

Overview:
- Owns the AVR core's Stack Pointer (SPH:SPL) and Status Register (SREG).
- Supplies spl_out/sph_out/sreg_out to the I/O read-back multiplexer.
- Sequences single-byte PUSH/POP and multi-byte CALL/RET/interrupt-entry stack transfers to data RAM.
- Applies I/O writes (OUT to 0x3D/0x3E/0x3F) and per-bit ALU flag updates to SREG.

Parameters:
- pc22b, 0: 0 = 2-byte return address (16-bit PC); 1 = 3-byte return address (22-bit PC).
- SP_RST, 16'h08FF: SP value after reset (RAMEND).
- SP_LIMIT, 16'h0100: lowest legal stack address; used only with SP_LIMIT_CHK_EN.

Ports:
- cp2  in  1  core clock
- ireset  in  1  reset; synchronous, active-high
- adr  in  6  I/O address
- iowe  in  1  I/O write strobe
- dbusout  in  8  I/O write data from core
- spl_out  out  8  SP[7:0]
- sph_out  out  8  SP[15:8]
- sreg_out  out  8  SREG
- sreg_fl_in  in  8  ALU flag values
- sreg_fl_we  in  8  per-bit SREG write enables from ALU
- sreg_i_clr  in  1  clear I flag (interrupt acknowledge)
- sreg_i_set  in  1  set I flag (RETI)
- push_req  in  1  PUSH one byte
- push_data  in  8  byte to push
- pop_req  in  1  POP one byte
- call_req  in  1  push return address (CALL/RCALL/ICALL/irq entry)
- ret_req  in  1  pop return address (RET/RETI)
- pc_in  in  22  return address to push; bits [21:16] ignored when pc22b=0
- stk_adr  out  16  stack RAM address
- stk_wdata  out  8  stack RAM write data
- stk_we  out  1  stack RAM write strobe
- stk_re  out  1  stack RAM read strobe
- stk_rdata  in  8  RAM read data, valid the cycle after stk_re
- pop_data  out  8  popped byte
- pop_vld  out  1  one-cycle pulse: pop_data valid
- pc_out  out  22  popped return address
- pc_vld  out  1  one-cycle pulse: pc_out valid
- busy  out  1  sequencer not idle
- stk_err  out  1  stack limit violation, sticky (SP_LIMIT_CHK_EN only)

Behaviour:
- Reset: SP=SP_RST; SREG=0; FSM=IDLE. stk_adr, stk_wdata, stk_we, stk_re, pop_data, pop_vld, pc_out, pc_vld, busy and stk_err all 0. Reset aborts any sequence mid-operation with no further RAM strobes.
- All stk_* outputs are registered. RAM model: 1-cycle read latency.
- FSM states: IDLE, PUSH, POP_RD, POP_CAP, CALL_B0, CALL_B1, CALL_B2, RET_B2, RET_B1, RET_B0, RET_CAP.
- Requests are sampled only in IDLE. Priority: call_req > ret_req > push_req > pop_req. Requests outside IDLE are ignored.
- busy=1 in every state except IDLE.
- PUSH: stk_we=1, stk_adr=SP, stk_wdata=push_data; SP-=1 on the same edge. Then return to IDLE.
- POP:
  - POP_RD: SP+=1; stk_re=1; stk_adr=new SP.
  - POP_CAP: pop_data=stk_rdata; pop_vld=1 for one cycle. Then IDLE.
- CALL: writes low byte first, one byte per cycle, SP-=1 per write.
  - CALL_B0 writes pc_in[7:0] at SP.
  - CALL_B1 writes pc_in[15:8] at SP-1.
  - CALL_B2 writes pc_in[21:16] zero-extended at SP-2; only when pc22b=1.
  - pc_in is latched at acceptance.
- RET: pre-increment reads, most-significant byte first.
  - RET_B2 runs only when pc22b=1.
  - Each state issues stk_re at SP+1 and sets SP+=1.
  - The byte from each read is captured in the following cycle.
  - RET_CAP assembles pc_out (bits [21:16]=0 when pc22b=0) and pulses pc_vld.
- SP arithmetic is modulo 2^16: 0x0000-1 = 0xFFFF; 0xFFFF+1 = 0x0000.
- I/O writes when iowe=1:
  - adr=0x3D loads SPL.
  - adr=0x3E loads SPH.
  - adr=0x3F loads SREG.
  - All take effect on the next edge.
- SP I/O write while busy=1: dropped.
- SP I/O write coinciding with request acceptance: I/O write wins and the request is discarded.
- SREG next-state priority, per bit: ireset > I/O write (adr=0x3F) > ALU per-bit enable.
  - For bit 7 (I), an I/O write takes priority over sreg_i_clr/sreg_i_set.
  - sreg_i_clr and sreg_i_set take priority over the ALU enable for bit 7.
  - sreg_i_clr wins over sreg_i_set.
- Outputs spl_out, sph_out and sreg_out reflect register contents directly, with no extra latency.

Optional Feature:
- Macro: SP_LIMIT_CHK_EN.
- When defined: stk_err is set, and held until ireset, on the first stk_we whose stk_adr < SP_LIMIT. The write still occurs.
- When undefined: stk_err is tied to 0 and there is no comparator logic.

Decomposition:
- Package avr_sp_sreg_pkg contains:
  - I/O address constants SPL=0x3D, SPH=0x3E, SREG=0x3F.
  - SREG bit-index constants I,T,H,S,V,N,Z,C.
  - The FSM state enum typedef.
- One sub-module, avr_sreg_upd: combinational per-bit SREG next-state logic. The SP and FSM remain in the top.

Test Plan:
- Reset, then read ports → spl_out=0xFF, sph_out=0x08, sreg_out=0x00, busy=0.
- push_req with push_data=0xA5 at SP=0x08FF → one stk_we at 0x08FF with data 0xA5; SP=0x08FE. Then pop_req → stk_re at 0x08FF; pop_data=0xA5 with pop_vld pulse; SP=0x08FF.
- pc22b=0, call_req with pc_in=0x1234 → writes 0x34@0x08FF then 0x12@0x08FE; SP=0x08FD. ret_req → pc_out=0x001234, pc_vld pulse, SP=0x08FF.
- pc22b=1, call/ret with pc_in=0x2ABCDE → three writes (0xDE, 0xBC, 0x2A) and three reads; pc_out=0x2ABCDE.
- iowe adr=0x3F data=0x80 in the same cycle as sreg_i_clr and sreg_fl_we=0x02 → SREG=0x80. Next cycle sreg_i_clr alone → SREG=0x00.
- SP=0x0000, push → write at 0x0000, SP wraps to 0xFFFF. With SP_LIMIT_CHK_EN, a push at 0x00FF → stk_err=1 and it stays set.
